// File: rtl/vx_mem_lat_monitor_if.sv
// Memory request/response handshake bundle tapped by the latency monitor.
// The master side owns every signal; the monitor only ever listens.
interface vx_mem_lat_monitor_if #(
  parameter int NUM_REQS = 4,
  parameter int NUM_RSPS = 4
);
  logic [NUM_REQS-1:0] req_valid;
  logic [NUM_REQS-1:0] req_ready;
  logic [NUM_REQS-1:0] req_rw;
  logic [NUM_RSPS-1:0] rsp_valid;
  logic [NUM_RSPS-1:0] rsp_ready;

  modport master (
    output req_valid,
    output req_ready,
    output req_rw,
    output rsp_valid,
    output rsp_ready
  );

  modport slave (
    input req_valid,
    input req_ready,
    input req_rw,
    input rsp_valid,
    input rsp_ready
  );
endinterface

// File: rtl/vx_mem_lat_monitor.sv
// Passive memory perf monitor: request counts, outstanding reads,
// cumulative read latency and peak outstanding, with snapshot/clear.
module vx_mem_lat_monitor #(
  parameter int NUM_REQS = 4,
  parameter int NUM_RSPS = 4,
  parameter int CTR_W    = 44,
  parameter int PEND_W   = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  vx_mem_lat_monitor_if.slave mem,
  input  logic              clear,
  input  logic              snap_req,
  output logic              snap_valid,
  output logic [CTR_W-1:0]  snap_reads,
  output logic [CTR_W-1:0]  snap_writes,
  output logic [CTR_W-1:0]  snap_lat,
  output logic [PEND_W-1:0] snap_peak,
  output logic [PEND_W-1:0] pending,
  output logic              underflow
);

  localparam int RQ_W  = $clog2(NUM_REQS + 1);
  localparam int RS_W  = $clog2(NUM_RSPS + 1);
  localparam int SUM_W = ((CTR_W > PEND_W) ? CTR_W : PEND_W) + 1;
  localparam int PN_W  = PEND_W + 2;

  localparam logic [SUM_W-1:0] CMAX =
    {{(SUM_W-CTR_W){1'b0}}, {CTR_W{1'b1}}};
  localparam logic [PN_W-1:0] PMAX =
    {2'b00, {PEND_W{1'b1}}};

  logic [NUM_REQS-1:0] rd_fire;
  logic [NUM_REQS-1:0] wr_fire;
  logic [NUM_REQS-1:0] rd_r;
  logic [NUM_REQS-1:0] wr_r;
  logic [NUM_RSPS-1:0] rsp_fire;

  assign rd_fire  = mem.req_valid & mem.req_ready & ~mem.req_rw;
  assign wr_fire  = mem.req_valid & mem.req_ready &  mem.req_rw;
  assign rsp_fire = mem.rsp_valid & mem.rsp_ready;

  logic [RQ_W-1:0] rd_cnt;
  logic [RQ_W-1:0] wr_cnt;
  logic [RS_W-1:0] rsp_cnt;

  always_comb begin
    rd_cnt  = '0;
    wr_cnt  = '0;
    rsp_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rd_cnt = rd_cnt + RQ_W'(rd_r[i]);
      wr_cnt = wr_cnt + RQ_W'(wr_r[i]);
    end
    for (int i = 0; i < NUM_RSPS; i++) begin
      rsp_cnt = rsp_cnt + RS_W'(rsp_fire[i]);
    end
  end

  // Signed headroom lets a surplus of responses show up as negative.
  logic signed [PN_W-1:0] pend_sum;
  logic [PEND_W-1:0]      pend_nx;
  logic                   pend_neg;

  assign pend_sum = $signed(PN_W'(pending))
                  + $signed(PN_W'(rd_cnt))
                  - $signed(PN_W'(rsp_cnt));
  assign pend_neg = pend_sum[PN_W-1];

  always_comb begin
    pend_nx = pend_sum[PEND_W-1:0];
    if (pend_neg) begin
      pend_nx = '0;
    end else if (SATURATE && ($unsigned(pend_sum) > PMAX)) begin
      pend_nx = '1;
    end
  end

  function automatic logic [CTR_W-1:0] ctr_add(
    input logic [CTR_W-1:0] a,
    input logic [SUM_W-1:0] b
  );
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + b;
    if (SATURATE && (s > CMAX)) ctr_add = '1;
    else                        ctr_add = s[CTR_W-1:0];
  endfunction

  logic [CTR_W-1:0]  reads;
  logic [CTR_W-1:0]  writes;
  logic [CTR_W-1:0]  lat;
  logic [PEND_W-1:0] peak;

  logic [CTR_W-1:0]  reads_nx;
  logic [CTR_W-1:0]  writes_nx;
  logic [CTR_W-1:0]  lat_nx;
  logic [PEND_W-1:0] peak_nx;

  assign reads_nx  = ctr_add(reads,  SUM_W'(rd_cnt));
  assign writes_nx = ctr_add(writes, SUM_W'(wr_cnt));
  assign lat_nx    = ctr_add(lat,    SUM_W'(pending));
  assign peak_nx   = (pend_nx > peak) ? pend_nx : peak;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_r        <= '0;
      wr_r        <= '0;
      pending     <= '0;
      underflow   <= 1'b0;
      reads       <= '0;
      writes      <= '0;
      lat         <= '0;
      peak        <= '0;
      snap_valid  <= 1'b0;
      snap_reads  <= '0;
      snap_writes <= '0;
      snap_lat    <= '0;
      snap_peak   <= '0;
    end else begin
      rd_r    <= rd_fire;
      wr_r    <= wr_fire;
      pending <= pend_nx;
      if (pend_neg) underflow <= 1'b1;
      // Snapshot sees the uncleared end-of-cycle values.
      if (clear) begin
        reads  <= '0;
        writes <= '0;
        lat    <= '0;
        peak   <= '0;
      end else begin
        reads  <= reads_nx;
        writes <= writes_nx;
        lat    <= lat_nx;
        peak   <= peak_nx;
      end
      snap_valid <= snap_req;
      if (snap_req) begin
        snap_reads  <= reads_nx;
        snap_writes <= writes_nx;
        snap_lat    <= lat_nx;
        snap_peak   <= peak_nx;
      end
    end
  end

endmodule

// File: tb/tb_vx_mem_lat_monitor.sv
// Randomized bench for vx_mem_lat_monitor against an integer model,
// over one wide saturating and two narrow wrap/saturate instances.
module tb_vx_mem_lat_monitor;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic snap_req;

  always #5 clk = ~clk;

  vx_mem_lat_monitor_if #(.NUM_REQS(4), .NUM_RSPS(4)) mem ();

  logic        a_sv, b_sv, c_sv;
  logic        a_uf, b_uf, c_uf;
  logic [43:0] a_rd, a_wr, a_lat;
  logic [15:0] a_pk, a_pn;
  logic [3:0]  b_rd, b_wr, b_lat, c_rd, c_wr, c_lat;
  logic [2:0]  b_pk, b_pn, c_pk, c_pn;

  vx_mem_lat_monitor #(
    .NUM_REQS(4), .NUM_RSPS(4), .CTR_W(44), .PEND_W(16), .SATURATE(1'b1)
  ) u_a (
    .clk(clk), .reset(reset), .mem(mem),
    .clear(clear), .snap_req(snap_req),
    .snap_valid(a_sv), .snap_reads(a_rd), .snap_writes(a_wr),
    .snap_lat(a_lat), .snap_peak(a_pk),
    .pending(a_pn), .underflow(a_uf)
  );

  vx_mem_lat_monitor #(
    .NUM_REQS(4), .NUM_RSPS(4), .CTR_W(4), .PEND_W(3), .SATURATE(1'b0)
  ) u_b (
    .clk(clk), .reset(reset), .mem(mem),
    .clear(clear), .snap_req(snap_req),
    .snap_valid(b_sv), .snap_reads(b_rd), .snap_writes(b_wr),
    .snap_lat(b_lat), .snap_peak(b_pk),
    .pending(b_pn), .underflow(b_uf)
  );

  vx_mem_lat_monitor #(
    .NUM_REQS(4), .NUM_RSPS(4), .CTR_W(4), .PEND_W(3), .SATURATE(1'b1)
  ) u_c (
    .clk(clk), .reset(reset), .mem(mem),
    .clear(clear), .snap_req(snap_req),
    .snap_valid(c_sv), .snap_reads(c_rd), .snap_writes(c_wr),
    .snap_lat(c_lat), .snap_peak(c_pk),
    .pending(c_pn), .underflow(c_uf)
  );

  int cw [3] = '{44, 4, 4};
  int pw [3] = '{16, 3, 3};
  int sat[3] = '{1, 0, 1};

  longint m_rd[3], m_wr[3], m_lat[3], m_pk[3], m_pn[3];
  longint s_rd[3], s_wr[3], s_lat[3], s_pk[3];
  bit     m_uf[3], m_sv[3];
  int     rd_q[$];
  int     wr_q[$];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint cadd(longint a, longint b, int w, int s);
    longint mx;
    longint t;
    mx = (longint'(1) << w) - 1;
    t  = a + b;
    if (t > mx) t = (s != 0) ? mx : (t & mx);
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_rd[i] = 0; m_wr[i] = 0; m_lat[i] = 0; m_pk[i] = 0; m_pn[i] = 0;
      s_rd[i] = 0; s_wr[i] = 0; s_lat[i] = 0; s_pk[i] = 0;
      m_uf[i] = 1'b0; m_sv[i] = 1'b0;
    end
    rd_q = '{0};
    wr_q = '{0};
  endtask

  // Requests are counted one cycle after they fire, hence the queues.
  task automatic model_edge(input logic [3:0] qv, qr, qw, pv, pr,
                            input logic cl, sn);
    int     rdn, wrn, rsp;
    longint nx, pmax, r, w, l, p;
    rdn = rd_q.pop_front();
    wrn = wr_q.pop_front();
    rd_q.push_back($countones(qv & qr & ~qw));
    wr_q.push_back($countones(qv & qr & qw));
    rsp = $countones(pv & pr);
    for (int i = 0; i < 3; i++) begin
      pmax = (longint'(1) << pw[i]) - 1;
      nx = m_pn[i] + rdn - rsp;
      if (nx < 0) begin
        nx = 0;
        m_uf[i] = 1'b1;
      end else if (nx > pmax) begin
        nx = (sat[i] != 0) ? pmax : (nx & pmax);
      end
      r = cadd(m_rd[i], rdn, cw[i], sat[i]);
      w = cadd(m_wr[i], wrn, cw[i], sat[i]);
      l = cadd(m_lat[i], m_pn[i], cw[i], sat[i]);
      p = (nx > m_pk[i]) ? nx : m_pk[i];
      m_sv[i] = sn;
      if (sn) begin
        s_rd[i] = r; s_wr[i] = w; s_lat[i] = l; s_pk[i] = p;
      end
      if (cl) begin
        m_rd[i] = 0; m_wr[i] = 0; m_lat[i] = 0; m_pk[i] = 0;
      end else begin
        m_rd[i] = r; m_wr[i] = w; m_lat[i] = l; m_pk[i] = p;
      end
      m_pn[i] = nx;
    end
  endtask

  task automatic compare_all();
    logic [63:0] g[3][7];
    logic [63:0] e[3][7];
    string nm[7] = '{"pending", "underflow", "snap_valid",
                     "snap_reads", "snap_writes", "snap_lat", "snap_peak"};
    g[0] = '{64'(a_pn), 64'(a_uf), 64'(a_sv), 64'(a_rd),
             64'(a_wr), 64'(a_lat), 64'(a_pk)};
    g[1] = '{64'(b_pn), 64'(b_uf), 64'(b_sv), 64'(b_rd),
             64'(b_wr), 64'(b_lat), 64'(b_pk)};
    g[2] = '{64'(c_pn), 64'(c_uf), 64'(c_sv), 64'(c_rd),
             64'(c_wr), 64'(c_lat), 64'(c_pk)};
    for (int i = 0; i < 3; i++) begin
      e[i] = '{64'(m_pn[i]), 64'(m_uf[i]), 64'(m_sv[i]), 64'(s_rd[i]),
               64'(s_wr[i]), 64'(s_lat[i]), 64'(s_pk[i])};
      for (int k = 0; k < 7; k++)
        check($sformatf("%s[%0d]", nm[k], i), g[i][k], e[i][k]);
    end
  endtask

  task automatic step(input logic [3:0] qv, qr, qw, pv, pr,
                      input logic cl, sn);
    mem.req_valid = qv;
    mem.req_ready = qr;
    mem.req_rw    = qw;
    mem.rsp_valid = pv;
    mem.rsp_ready = pr;
    clear         = cl;
    snap_req      = sn;
    @(posedge clk);
    model_edge(qv, qr, qw, pv, pr, cl, sn);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic cl, sn);
    step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, cl, sn);
  endtask

  task automatic do_reset();
    mem.req_valid = '0;
    mem.req_ready = '0;
    mem.req_rw    = '0;
    mem.rsp_valid = '0;
    mem.rsp_ready = '0;
    clear    = 1'b0;
    snap_req = 1'b0;
    reset    = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] rv(int pct);
    logic [3:0] v;
    for (int b = 0; b < 4; b++) v[b] = ($urandom_range(99) < pct);
    return v;
  endfunction

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    snap_req = 1'b0;
    mem.req_valid = '0;
    mem.req_ready = '0;
    mem.req_rw    = '0;
    mem.rsp_valid = '0;
    mem.rsp_ready = '0;
    model_reset();
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    // Single read, response five cycles later.
    step(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("t1_pend_T2", 64'(a_pn), 64'd1);
    repeat (3) idle(1'b0, 1'b0);
    step(4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0);
    check("t1_pend_T6", 64'(a_pn), 64'd0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    check("t1_reads", 64'(a_rd), 64'd1);
    check("t1_lat", 64'(a_lat), 64'd4);
    check("t1_peak", 64'(a_pk), 64'd1);

    // Burst of 12 reads then 12 responses.
    idle(1'b1, 1'b0);
    repeat (3) step(4'hf, 4'hf, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    repeat (3) step(4'h0, 4'h0, 4'h0, 4'hf, 4'hf, 1'b0, 1'b0);
    idle(1'b0, 1'b1);
    check("t2_reads", 64'(a_rd), 64'd12);
    check("t2_peak", 64'(a_pk), 64'd12);
    check("t2_pend", 64'(a_pn), 64'd0);
    check("t2_uf", 64'(a_uf), 64'd0);

    // Write on ch0 and read on ch1 every cycle.
    idle(1'b1, 1'b0);
    repeat (10) step(4'h3, 4'h3, 4'h1, 4'h2, 4'h2, 1'b0, 1'b0);
    repeat (2) idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    check("t3_writes", 64'(a_wr), 64'd10);
    check("t3_reads", 64'(a_rd), 64'd10);

    // Stray response: underflow is sticky across clear.
    do_reset();
    step(4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0);
    check("t4_uf", 64'(a_uf), 64'd1);
    check("t4_pend", 64'(a_pn), 64'd0);
    idle(1'b1, 1'b0);
    check("t4_uf_clear", 64'(a_uf), 64'd1);
    do_reset();
    check("t4_uf_reset", 64'(a_uf), 64'd0);

    // Counter saturation vs wrap with a 4-bit counter.
    repeat (20) step(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    check("t5_reads_wide", 64'(a_rd), 64'd20);
    check("t5_reads_wrap", 64'(b_rd), 64'd4);
    check("t5_reads_sat", 64'(c_rd), 64'd15);

    // Clear and snapshot in the same cycle.
    do_reset();
    repeat (7) step(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) idle(1'b0, 1'b0);
    step(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    check("t6_snap_reads", 64'(a_rd), 64'd8);
    check("t6_pend", 64'(a_pn), 64'd8);
    idle(1'b0, 1'b1);
    check("t6_next_reads", 64'(a_rd), 64'd0);
    check("t6_pend_hold", 64'(a_pn), 64'd8);

    // Snapshot held high for a stretch.
    repeat (20)
      step(rv(50), rv(70), rv(50), rv(30), rv(70), 1'b0, 1'b1);

    // Randomized traffic at several densities.
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(299) == 0) do_reset();
        step(rv(30 + 20 * ph), rv(80), rv(40), rv(15 + 15 * ph), rv(80),
             ($urandom_range(31) == 0), ($urandom_range(7) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
